uart_program_loader: RTL and testbench

//  Upstream feeder for the 8-bit CPU's programming port. Receives a 16-byte program image over UART (8N1)

---
 rtl/loader_pkg.sv | 15 +
 rtl/uart_rx_8n1.sv | 115 +++++++++++
 rtl/uart_program_loader.sv | 134 +++++++++++++
 tb/tb_uart_program_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared encodings for the UART program loader: RX framing FSM and loader FSM states.
package loader_pkg;

   localparam int UART_DATA_BITS = 8;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [1:0] LD_FILL      = 2'd0;
   localparam logic [1:0] LD_STREAM    = 2'd1;
   localparam logic [1:0] LD_WAIT_DONE = 2'd2;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchroniser, down-counting bit timer, LSB-first shift register.
//  state    | meaning
//  RX_IDLE  | line idle, waiting for a high-to-low transition
//  RX_START | timing to the middle of the start bit; high there means glitch
//  RX_DATA  | sampling 8 data bits, one per bit period
//  RX_STOP  | sampling the stop bit; high -> byte_valid, low -> frame_err
module uart_rx_8n1
   import loader_pkg::*;
#(
   parameter int CLK_DIV = 87
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx_i,
   output logic                      start_o,
   output logic [UART_DATA_BITS-1:0] byte_o,
   output logic                      byte_valid_o,
   output logic                      frame_err_o
);

   localparam logic [9:0] BIT_TC   = 10'(CLK_DIV - 1);
   localparam logic [9:0] HALF_TC  = 10'(CLK_DIV / 2 - 1);
   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic                      sync1_q, sync2_q, prev_q;
   logic [1:0]                state_q, state_d;
   logic [9:0]                cnt_q, cnt_d;
   logic [2:0]                bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      valid_q, valid_d;
   logic                      ferr_q, ferr_d;
   logic                      fall;

   // prev_q tracks the synchronised line so only a genuine high-to-low edge starts a frame
   assign fall         = prev_q & ~sync2_q;
   assign start_o      = (state_q == RX_IDLE) & fall;
   assign byte_o       = shift_q;
   assign byte_valid_o = valid_q;
   assign frame_err_o  = ferr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (fall) begin
               state_d = RX_START;
               cnt_d   = HALF_TC;
            end
         end
         RX_START: begin
            if (cnt_q == '0) begin
               if (sync2_q) begin
                  state_d = RX_IDLE;
               end else begin
                  state_d = RX_DATA;
                  cnt_d   = BIT_TC;
                  bit_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - 10'd1;
            end
         end
         RX_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {sync2_q, shift_q[UART_DATA_BITS-1:1]};
               cnt_d   = BIT_TC;
               if (bit_q == LAST_BIT) state_d = RX_STOP;
               else                   bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q - 10'd1;
            end
         end
         RX_STOP: begin
            if (cnt_q == '0) begin
               state_d = RX_IDLE;
               valid_d = sync2_q;
               ferr_d  = ~sync2_q;
            end else begin
               cnt_d = cnt_q - 10'd1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

endmodule

// File: rtl/uart_program_loader.sv
// Receives a program image over UART into a local buffer, then streams it to the CPU programming port.
//  state        | meaning
//  LD_FILL      | collecting bytes from UART into the buffer
//  LD_STREAM    | prog_o high, presenting buf[rd_ptr], advancing on each ready fall
//  LD_WAIT_DONE | all bytes handed over, data_o=00, waiting for cpu_done_i
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int CLK_DIV    = 87,
   parameter int PROG_BYTES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   input  logic       cpu_ready_i,
   input  logic       cpu_done_i,
   output logic       prog_o,
   output logic [7:0] data_o,
   output logic       busy_o,
   output logic       frame_err_o,
   output logic       overflow_o
);

   localparam int               PTR_W    = $clog2(PROG_BYTES);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(PROG_BYTES - 1);

   logic                      rx_start, rx_valid, rx_ferr;
   logic [UART_DATA_BITS-1:0] rx_byte;

   logic [7:0]       mem_q [PROG_BYTES];
   logic [1:0]       state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             busy_q, busy_d, ferr_q, ferr_d, ovf_q, ovf_d;
   logic             rdy_prev_q, prog_q;
   logic [7:0]       data_q;
   logic             wr_en, ready_fall;

   uart_rx_8n1 #(.CLK_DIV(CLK_DIV)) u_rx (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_i         (rx_i),
      .start_o      (rx_start),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_valid),
      .frame_err_o  (rx_ferr)
   );

   assign ready_fall  = rdy_prev_q & ~cpu_ready_i;
   assign prog_o      = prog_q;
   assign data_o      = data_q;
   assign busy_o      = busy_q;
   assign frame_err_o = ferr_q;
   assign overflow_o  = ovf_q;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      busy_d   = busy_q;
      ferr_d   = ferr_q | rx_ferr;
      ovf_d    = ovf_q;
      wr_en    = 1'b0;
      case (state_q)
         LD_FILL: begin
            if (rx_start) busy_d = 1'b1;
            if (rx_valid) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
               // first byte of a new image starts a clean error history
               if (wr_ptr_q == '0) begin
                  ferr_d = 1'b0;
                  ovf_d  = 1'b0;
               end
               if (wr_ptr_q == LAST_PTR) begin
                  state_d  = LD_STREAM;
                  rd_ptr_d = '0;
               end
            end
         end
         LD_STREAM: begin
            if (rx_valid) ovf_d = 1'b1;
            if (cpu_done_i) begin
               state_d  = LD_FILL;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               busy_d   = 1'b0;
            end else if (ready_fall) begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
               if (rd_ptr_q == LAST_PTR) state_d = LD_WAIT_DONE;
            end
         end
         LD_WAIT_DONE: begin
            if (rx_valid) ovf_d = 1'b1;
            if (cpu_done_i) begin
               state_d  = LD_FILL;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               busy_d   = 1'b0;
            end
         end
         default: state_d = LD_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= rx_byte;
   end

   // prog_o rises one cycle after entering STREAM (so buf[0] is readable) and drops on leaving
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= LD_FILL;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         busy_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovf_q      <= 1'b0;
         rdy_prev_q <= 1'b0;
         prog_q     <= 1'b0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         busy_q     <= busy_d;
         ferr_q     <= ferr_d;
         ovf_q      <= ovf_d;
         rdy_prev_q <= (state_q == LD_STREAM) & cpu_ready_i;
         prog_q     <= (state_q != LD_FILL) & (state_d != LD_FILL);
         data_q     <= ((state_q == LD_STREAM) && (state_d == LD_STREAM)) ? mem_q[rd_ptr_d] : 8'h00;
      end
   end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: drives UART frames and a CPU ready/done model.
module tb_uart_program_loader;

   localparam int CLK_DIV = 4;
   localparam int NB      = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       cpu_ready = 1'b0;
   logic       cpu_done = 1'b0;
   logic       prog, busy, ferr, ovf;
   logic [7:0] data;

   int tests = 0;
   int fails = 0;

   // reference model: image as the bench sent it, plus loader mode and sticky flags
   logic [7:0] mbuf [NB];
   int         m_wr = 0;
   int         m_rd = 0;
   bit         m_fill = 1'b1;
   bit         m_ferr = 1'b0;
   bit         m_ovf = 1'b0;

   always #5 clk = ~clk;

   uart_program_loader #(.CLK_DIV(CLK_DIV), .PROG_BYTES(NB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_i        (rx),
      .cpu_ready_i (cpu_ready),
      .cpu_done_i  (cpu_done),
      .prog_o      (prog),
      .data_o      (data),
      .busy_o      (busy),
      .frame_err_o (ferr),
      .overflow_o  (ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_fill) begin
         if (m_wr == 0) begin
            m_ferr = 1'b0;
            m_ovf  = 1'b0;
         end
         mbuf[m_wr] = b;
         m_wr++;
         if (m_wr == NB) begin
            m_fill = 1'b0;
            m_rd   = 0;
         end
      end else begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic model_reset();
      m_fill = 1'b1;
      m_wr   = 0;
      m_rd   = 0;
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      logic [9:0] fr;
      fr = {stop_ok, b, 1'b0};
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         repeat (CLK_DIV) @(posedge clk);
         #1;
      end
      rx = 1'b1;
      if (stop_ok) model_byte(b);
      else         m_ferr = 1'b1;
   endtask

   task automatic send_random(input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         send_byte(b, 1'b1);
      end
   endtask

   task automatic wait_prog(input string name);
      int n;
      n = 0;
      while (prog !== 1'b1 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, prog, 1);
   endtask

   task automatic stream(input int n);
      int hi, lo;
      for (int i = 0; i < n; i++) begin
         hi = $urandom_range(1, 3);
         lo = $urandom_range(3, 5);
         cpu_ready = 1'b1;
         repeat (hi) @(posedge clk);
         #1;
         cpu_ready = 1'b0;
         m_rd++;
         repeat (lo) @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_done(input string name);
      cpu_done = 1'b1;
      @(posedge clk); #1;
      cpu_done = 1'b0;
      model_reset_pointers();
      check({name, "_prog"}, prog, 0);
      check({name, "_busy"}, busy, 0);
   endtask

   task automatic model_reset_pointers();
      m_fill = 1'b1;
      m_wr   = 0;
      m_rd   = 0;
   endtask

   task automatic settle_flags(input string name);
      repeat (3) @(posedge clk);
      #1;
      check({name, "_ferr"}, ferr, 32'(m_ferr));
      check({name, "_ovf"}, ovf, 32'(m_ovf));
   endtask

   // every cycle the CPU holds ready high, the presented byte must be the next image byte
   always @(negedge clk) begin
      if (rst_n && cpu_ready && !m_fill && m_rd < NB)
         check("stream_data", data, mbuf[m_rd]);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_prog", prog, 0);
      check("rst_data", data, 0);
      check("rst_busy", busy, 0);
      check("rst_ferr", ferr, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("idle_prog", prog, 0);
      check("idle_busy", busy, 0);

      // image 10..1F with exact prog latency
      for (int i = 0; i < NB; i++) begin
         send_byte(8'(8'h10 + i), 1'b1);
         if (i == 0) check("busy_first_start", busy, 1);
      end
      @(posedge clk);
      @(posedge clk); #1;
      check("prog_lat_early", prog, 0);
      @(posedge clk); #1;
      check("prog_lat", prog, 1);
      check("first_byte", data, 8'h10);
      check("stream_busy", busy, 1);
      stream(1);
      check("second_byte", data, 8'h11);
      stream(NB - 1);
      check("wait_done_data", data, 8'h00);
      check("wait_done_prog", prog, 1);
      pulse_done("done1");

      // frame error, recovery, short glitch
      send_byte(8'hA5, 1'b0);
      settle_flags("ferr_set");
      check("ferr_literal", ferr, 1);
      send_random(1);
      settle_flags("ferr_clear");
      check("ferr_clear_literal", ferr, 0);
      @(posedge clk); #1;
      rx = 1'b0;
      @(posedge clk); #1;
      rx = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      send_random(NB - 1);
      wait_prog("prog_img2");

      // byte arriving during STREAM
      fork
         send_byte(8'h77, 1'b1);
         stream(NB);
      join
      settle_flags("ovf_set");
      check("ovf_literal", ovf, 1);
      check("ovf_data_after", data, 8'h00);
      pulse_done("done2");

      // early accept after 5 handshakes, then a new image from buf[0]
      send_random(1);
      settle_flags("ovf_clear");
      check("ovf_clear_literal", ovf, 0);
      send_random(NB - 1);
      wait_prog("prog_img3");
      stream(5);
      pulse_done("early_done");
      check("early_done_data", data, 8'h00);
      send_random(NB);
      wait_prog("prog_img4");
      stream(NB);
      check("img4_wait_data", data, 8'h00);
      pulse_done("done4");

      // async reset during STREAM and during an RX data bit
      send_random(NB);
      wait_prog("prog_img5");
      stream(8);
      @(posedge clk); #1;
      rx = 1'b0;
      repeat (CLK_DIV) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_prog", prog, 0);
      check("midrst_data", data, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ferr", ferr, 0);
      check("midrst_ovf", ovf, 0);
      model_reset();
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_prog", prog, 0);
      send_random(NB);
      wait_prog("prog_img6");
      stream(NB);
      check("img6_wait_data", data, 8'h00);
      pulse_done("done6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
